vmem_rect_fill: RTL
===================

VMEM_RECT_FILL -- requirements
Module: vmem_rect_fill

Interface
REQ-001 Parameter MAX_COL, default 79: last visible tile column; writes beyond it are clipped.
REQ-002 Parameter MAX_ROW, default 59: last visible tile row; writes beyond it are clipped.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid  in  1  fill command present.
REQ-006 cmd_ready  out  1  block accepts a command this cycle.
REQ-007 cmd_x0, cmd_x1  in  7 each  first and last column, inclusive.
REQ-008 cmd_y0, cmd_y1  in  6 each  first and last row, inclusive.
REQ-009 cmd_color  in  24  fill colour {R[23:16],G[15:8],B[7:0]}.
REQ-010 mem_waddr  out  13  video-memory write address {row[5:0], col[6:0]}.
REQ-011 mem_wdata  out  24  video-memory write data.
REQ-012 mem_web  out  1  write enable, active-high, one word per asserted cycle.
REQ-013 busy  out  1  high while a command is being executed.
REQ-014 done  out  1  single-cycle pulse on command completion.

Function
REQ-015 The block SHALL have states IDLE, FILL and DONE.
REQ-016 cmd_ready SHALL be high in IDLE only; a command is accepted on a clock edge where cmd_valid and cmd_ready are both high.
REQ-017 On acceptance the block SHALL register the coordinates and colour; later changes to cmd_* SHALL have no effect.
REQ-018 Clipping: x1 SHALL be replaced by min(x1, MAX_COL) and y1 by min(y1, MAX_ROW) when the command is accepted.
REQ-019 If x0 > clipped x1 or y0 > clipped y1, the block SHALL go to DONE with zero writes.
REQ-020 Otherwise it SHALL go to FILL, and the first write SHALL appear in the cycle after acceptance at (x0, y0).
REQ-021 In FILL the block SHALL issue exactly one write per cycle with no gaps, in row-major order: col increments; after col == x1, col reloads x0 and row increments.
REQ-022 The total writes SHALL equal (x1-x0+1)*(y1-y0+1) using the clipped values.
REQ-023 The write at (x1, y1) SHALL be the last one, and the next state SHALL be DONE.
REQ-024 DONE SHALL last one cycle with done=1 and mem_web=0, then return to IDLE.
REQ-025 busy SHALL be high in FILL and DONE.
REQ-026 mem_waddr, mem_wdata and mem_web SHALL be registered outputs.
REQ-027 mem_wdata SHALL equal the latched colour whenever mem_web=1.
REQ-028 Counter arithmetic SHALL not wrap: column counting stops at x1 (at most 127) and row counting stops at y1 (at most 63).
REQ-029 A single-tile command (x0==x1, y0==y1) SHALL produce exactly one write followed by done.

Reset
REQ-030 While reset is high: state=IDLE, mem_web=0, mem_waddr=0, mem_wdata=0, busy=0, done=0, cmd_ready=0.
REQ-031 cmd_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-032 Reset during FILL SHALL abort the command: no further writes, and no done pulse.

Structure
REQ-033 Package vmem_pkg SHALL hold ADDR_W=13, DATA_W=24, COL_W=7, ROW_W=6 and the state enum.
REQ-034 A sub-module raster_counter SHALL contain the col/row counter with load, step and last-flag.
REQ-035 The write port SHALL connect directly to the video-memory write port (addrb/datab/web, clkb=clk).

Verification
REQ-036 Command x0=2, x1=4, y0=1, y1=2, colour 0xFF0000 -> 6 consecutive writes at addresses 130, 131, 132, 258, 259, 260, all with data 0xFF0000, then done one cycle later.
REQ-037 Command x0=x1=79, y0=y1=59 -> one write at address 7631, then done; cmd_ready high the following cycle.
REQ-038 Command x0=70, x1=120, y0=58, y1=63 -> clipped to 10x2 = 20 writes, no column >79, no row >59.
REQ-039 Command x0=5, x1=3 -> zero writes; done pulses in the cycle after acceptance.
REQ-040 Full-screen fill of 0x00FF00 (0..79, 0..59) -> exactly 4800 gapless writes; busy high for 4801 cycles.
REQ-041 Reset asserted on the 3rd write of the first scenario -> mem_web=0 from the next cycle, no done, IDLE and ready after reset.

Source files
------------

// File: rtl/vmem_pkg.sv
// ---------------------------------------------------------------------------
// vmem_pkg
// Shared types and helpers for the video-memory rectangle filler.
//   ADDR_W / DATA_W : video-memory write port geometry
//   COL_W  / ROW_W  : tile column / row coordinate widths
//   state_e         : fill controller states
//   rect_t          : inclusive tile rectangle {x0, x1, y0, y1}
// ---------------------------------------------------------------------------
package vmem_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 24;
  localparam int COL_W  = 7;
  localparam int ROW_W  = 6;

  typedef logic [COL_W-1:0]  col_t;
  typedef logic [ROW_W-1:0]  row_t;
  typedef logic [DATA_W-1:0] color_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    col_t x0;
    col_t x1;
    row_t y0;
    row_t y1;
  } rect_t;

  // Clamp the far corner to the visible screen; the near corner is left
  // alone so an off-screen start naturally yields an empty rectangle.
  function automatic rect_t clip_rect(input rect_t r, input col_t max_col,
                                      input row_t max_row);
    rect_t c;
    c = r;
    if (r.x1 > max_col) c.x1 = max_col;
    if (r.y1 > max_row) c.y1 = max_row;
    return c;
  endfunction

  function automatic logic rect_empty(input rect_t r);
    return (r.x0 > r.x1) || (r.y0 > r.y1);
  endfunction

  // Video memory is laid out as {row, col}: 128 words per row.
  function automatic addr_t tile_addr(input row_t row, input col_t col);
    return {row, col};
  endfunction

endpackage

// File: rtl/raster_counter.sv
// ---------------------------------------------------------------------------
// raster_counter
// Row-major column/row walker over an inclusive tile rectangle.
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   i_load          : latch start corner and limits, position := (x0, y0)
//   i_step          : advance one tile (col first, then row)
//   i_x0, i_x1      : first / last column (x1 already clipped)
//   i_y0, i_y1      : first / last row    (y1 already clipped)
//   o_col, o_row    : current position (registered)
//   o_last          : current position is (x1, y1)
// ---------------------------------------------------------------------------
module raster_counter
  import vmem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_step,
  input  col_t i_x0,
  input  col_t i_x1,
  input  row_t i_y0,
  input  row_t i_y1,
  output col_t o_col,
  output row_t o_row,
  output logic o_last
);

  col_t r_col;
  col_t r_x0;
  col_t r_x1;
  row_t r_row;
  row_t r_y1;

  logic w_col_end;
  logic w_row_end;

  assign w_col_end = (r_col == r_x1);
  assign w_row_end = (r_row == r_y1);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col <= '0;
      r_row <= '0;
      r_x0  <= '0;
      r_x1  <= '0;
      r_y1  <= '0;
    end else if (i_load) begin
      r_col <= i_x0;
      r_row <= i_y0;
      r_x0  <= i_x0;
      r_x1  <= i_x1;
      r_y1  <= i_y1;
    end else if (i_step) begin
      // Counting stops at the limits, so neither counter can wrap even
      // when x1 = 127 or y1 = 63.
      if (!w_col_end) begin
        r_col <= r_col + 1'b1;
      end else if (!w_row_end) begin
        r_col <= r_x0;
        r_row <= r_row + 1'b1;
      end
    end
  end

  assign o_col  = r_col;
  assign o_row  = r_row;
  assign o_last = w_col_end && w_row_end;

endmodule

// File: rtl/vmem_rect_fill.sv
// ---------------------------------------------------------------------------
// vmem_rect_fill
// Fills an inclusive tile rectangle of video memory with one colour, one
// word per clock, in row-major order. The write port drives the memory's
// second port directly (addrb = mem_waddr, datab = mem_wdata, web = mem_web,
// clkb = clk).
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only in IDLE)
//   cmd_x0, cmd_x1      : first / last column, inclusive
//   cmd_y0, cmd_y1      : first / last row, inclusive
//   cmd_color           : fill colour {R, G, B}
//   mem_waddr           : write address {row, col} (registered)
//   mem_wdata           : write data (registered)
//   mem_web             : write enable, one word per high cycle (registered)
//   busy                : high in FILL and DONE
//   done                : one-cycle completion pulse
// ---------------------------------------------------------------------------
module vmem_rect_fill
  import vmem_pkg::*;
#(
  parameter int MAX_COL = 79,
  parameter int MAX_ROW = 59
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [COL_W-1:0]  cmd_x0,
  input  logic [COL_W-1:0]  cmd_x1,
  input  logic [ROW_W-1:0]  cmd_y0,
  input  logic [ROW_W-1:0]  cmd_y1,
  input  logic [DATA_W-1:0] cmd_color,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_web,
  output logic              busy,
  output logic              done
);

  localparam col_t LAST_COL = col_t'(MAX_COL);
  localparam row_t LAST_ROW = row_t'(MAX_ROW);

  state_e r_state;
  logic   r_web;
  logic   r_busy;
  logic   r_done;
  color_t r_wdata;

  rect_t  w_cmd_rect;
  rect_t  w_clip_rect;
  logic   w_accept;
  logic   w_empty;
  logic   w_load;
  logic   w_step;
  logic   w_last;
  col_t   w_col;
  row_t   w_row;

  // Ready is gated by reset so it is low throughout reset and high in the
  // very first cycle after reset is released, without waiting for an edge.
  assign cmd_ready = (r_state == ST_IDLE) && !reset;
  assign w_accept  = cmd_valid && cmd_ready;

  assign w_cmd_rect  = '{x0: cmd_x0, x1: cmd_x1, y0: cmd_y0, y1: cmd_y1};
  assign w_clip_rect = clip_rect(w_cmd_rect, LAST_COL, LAST_ROW);
  assign w_empty     = rect_empty(w_clip_rect);

  // Loading on acceptance puts (x0, y0) on the address outputs in the very
  // next cycle, together with mem_web, so there is no lead-in bubble.
  assign w_load = w_accept && !w_empty;
  assign w_step = (r_state == ST_FILL) && !w_last;

  raster_counter u_raster (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_step (w_step),
    .i_x0   (w_clip_rect.x0),
    .i_x1   (w_clip_rect.x1),
    .i_y0   (w_clip_rect.y0),
    .i_y1   (w_clip_rect.y1),
    .o_col  (w_col),
    .o_row  (w_row),
    .o_last (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_web   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_accept) begin
            r_busy <= 1'b1;
            if (w_empty) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_FILL;
              r_web   <= 1'b1;
              r_wdata <= cmd_color;
            end
          end
        end

        ST_FILL: begin
          // The word on the port this cycle is (x1, y1): it is the last one.
          if (w_last) begin
            r_state <= ST_DONE;
            r_web   <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end

        // NOTE: the spare encoding recovers to IDLE instead of holding state,
        // so an upset can never leave the controller stuck.
        default: begin
          r_state <= ST_IDLE;
          r_web   <= 1'b0;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_waddr = tile_addr(w_row, w_col);
  assign mem_wdata = r_wdata;
  assign mem_web   = r_web;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
